mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Sequences one pipelined multiply-accumulate engine through a length-N dot product.
//  A command supplies N; N operand pairs stream in over valid/ready; one accumulated result streams out.
//  Sits between the conv-layer scheduler (commands, operands) and the result writeback path.
// PARAMETERS
//  WIDTH     16    operand width, unsigned
//  MAX_LEN   1024  largest legal command length
//  LEN_W     derived = $clog2(MAX_LEN+1); width of cmd_len and of the internal counter
//  ACC_W     derived = 2*WIDTH+LEN_W; accumulator/result width
// PORTS
//  clock      in   1      single clock, rising edge
//  reset_n    in   1      synchronous, active-low reset
//  abort      in   1      synchronous cancel of the current job
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      command accepted when cmd_valid&&cmd_ready
//  cmd_len    in   LEN_W  number of operand pairs, N
//  op_valid   in   1      operand pair offered
//  op_ready   out  1      operand pair accepted when op_valid&&op_ready
//  op_x       in   WIDTH  operand x
//  op_y       in   WIDTH  operand y
//  res_valid  out  1      result available
//  res_ready  in   1      result consumed when res_valid&&res_ready
//  res_data   out  ACC_W  sum of x*y over the N accepted pairs
//  busy       out  1      high when state!=IDLE
// BEHAVIOUR
//  Reset: reset_n low at any edge -> state IDLE, counter 0, prod_q 0, acc 0, pipeline flag 0.
//   Outputs after reset: cmd_ready=1, op_ready=0, res_valid=0, res_data=0, busy=0.
//   Reset mid-job discards the job; no result is produced.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//  IDLE: cmd_ready=1. On cmd accept: acc<=0, cnt<=0, len_q<=min(cmd_len,MAX_LEN).
//   Next state is DONE if len_q==0, else RUN.
//  RUN: op_ready=1. On op accept: prod_q<=op_x*op_y (full 2*WIDTH bits), pv<=1, cnt<=cnt+1.
//   Without an op accept: pv<=0.
//   The accept with cnt==len_q-1 moves to DRAIN.
//   op_valid gaps stall; no timeout.
//  Accumulator: every edge with pv==1 does acc<=acc+prod_q (prod_q zero-extended to ACC_W).
//   Arithmetic is unsigned; wrap is modulo 2^ACC_W.
//   Overflow is impossible for N<=MAX_LEN.
//  DRAIN: op_ready=0. Lasts exactly 1 cycle (the final add), then DONE.
//  DONE: res_valid=1 and res_data=acc, both held stable until res_ready; then IDLE.
//   res_data reads 0 outside DONE.
//  Latency: res_valid rises 2 cycles after the edge that accepts the last pair.
//   For N==0, res_valid rises 1 cycle after the command edge.
//  Throughput: 1 pair/cycle. Job occupancy is N+3 cycles with zero-wait handshakes.
//  cmd_ready is 0 outside IDLE. A cmd_valid arriving in DONE waits, even if res_ready is high that cycle.
//  abort (reset_n high) in RUN/DRAIN/DONE: next state IDLE, pv<=0, acc<=0, no result.
//   An op offered in the abort cycle is not accepted (op_ready=0).
//   abort in IDLE is ignored and does not block a same-cycle cmd accept.
//  Priority: reset_n > abort > handshakes.
//  op_x/op_y are ignored unless op_valid&&op_ready.
// STRUCTURE
//  mac_pkg: state encoding localparams (IDLE/RUN/DRAIN/DONE) and the LEN_W/ACC_W derivation.
//  Sub-module mac_acc_unit: prod_q register, pv flag, accumulator with clr/en inputs.
//   Its reset is active-low synchronous.
//  Top level holds the FSM, the length counter and all handshake logic.
// TESTING
//  1. N=4, pairs (1,2),(3,4),(5,6),(7,8), no stalls -> res_data=100, res_valid 2 cycles after the 4th accept.
//  2. N=0 -> res_valid the next cycle, res_data=0, no op_ready pulse.
//  3. N=3, all pairs (0xFFFF,0xFFFF), op_valid gaps plus res_ready held low 5 cycles
//     -> res_data=3*0xFFFE0001 held stable, then IDLE.
//  4. cmd_len=2000 -> clamped to 1024 accepts; with all pairs (1,1), res_data=1024.
//  5. abort after 2 of 5 pairs, then a new N=1 job (9,9) -> only res_data=81 is ever seen.
//  6. reset_n low in DONE -> res_valid=0, busy=0, cmd_ready=1 the next cycle; then N=1 job (2,3) -> 6.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and width derivations for the MAC dot-product sequencer.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic cmd_ready;
        logic op_ready;
        logic res_valid;
        logic busy;
    } flags_t;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int calc_acc_w(input int width, input int len_w);
        return 2 * width + len_w;
    endfunction

    // Output flags are a pure function of state so they can be registered from next-state.
    function automatic flags_t state_flags(input state_t s);
        flags_t f;
        f.cmd_ready = (s == IDLE);
        f.op_ready  = (s == RUN);
        f.res_valid = (s == DONE);
        f.busy      = (s != IDLE);
        return f;
    endfunction

endpackage

// File: rtl/mac_acc_unit.sv
// Pipelined multiply-accumulate: product register, product-valid flag and accumulator.
module mac_acc_unit
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 43
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [ACC_W-1:0]   acc
);

    logic [2*WIDTH-1:0] prod_q;
    logic               pv;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prod_q <= '0;
            pv     <= 1'b0;
            acc    <= '0;
        end else begin
            if (load) begin
                prod_q <= (2*WIDTH)'(x) * (2*WIDTH)'(y);
            end
            pv <= load && !clr;
            // Clearing wins over a pending add so an abort in DRAIN leaves nothing behind.
            if (clr) begin
                acc <= '0;
            end else if (pv) begin
                acc <= acc + ACC_W'(prod_q);
            end
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Sequences one pipelined MAC engine through a length-N dot product with valid/ready streams.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int MAX_LEN = 1024,
    localparam int LEN_W   = calc_len_w(MAX_LEN),
    localparam int ACC_W   = calc_acc_w(WIDTH, LEN_W)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             abort,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    flags_t           flags_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_clamped;
    logic [ACC_W-1:0] acc;
    logic             cmd_fire;
    logic             op_fire;
    logic             res_fire;
    logic             abort_job;
    logic             last_pair;

    // Abort masks op/result handshakes combinationally so nothing is exchanged in the abort cycle.
    assign cmd_ready = flags_q.cmd_ready;
    assign op_ready  = flags_q.op_ready && !abort;
    assign res_valid = flags_q.res_valid && !abort;
    assign busy      = flags_q.busy;
    assign res_data  = flags_q.res_valid ? acc : '0;

    always_comb begin
        cmd_fire    = cmd_valid && cmd_ready;
        op_fire     = op_valid && op_ready;
        res_fire    = res_valid && res_ready;
        abort_job   = abort && (state != IDLE);
        len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
        last_pair   = (cnt == len_q - LEN_W'(1));
    end

    always_comb begin
        state_nxt = state;
        if (abort_job) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cmd_fire) state_nxt = (len_clamped == '0) ? DONE : RUN;
                RUN:     if (op_fire && last_pair) state_nxt = DRAIN;
                DRAIN:   state_nxt = DONE;
                DONE:    if (res_fire) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            flags_q <= state_flags(IDLE);
            cnt     <= '0;
            len_q   <= '0;
        end else begin
            state   <= state_nxt;
            flags_q <= state_flags(state_nxt);
            if (cmd_fire) begin
                cnt   <= '0;
                len_q <= len_clamped;
            end else if (op_fire) begin
                cnt <= cnt + LEN_W'(1);
            end
        end
    end

    mac_acc_unit #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_acc (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cmd_fire || abort_job),
        .load    (op_fire),
        .x       (op_x),
        .y       (op_y),
        .acc     (acc)
    );

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed self-checking bench for mac_dot_sequencer with hand-computed expectations.
module tb_mac_dot_sequencer;

    localparam int LEN_W = 11;
    localparam int ACC_W = 43;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             abort;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_x;
    logic [15:0]      op_y;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    mac_dot_sequencer #(
        .WIDTH   (16),
        .MAX_LEN (1024)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .abort     (abort),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_x      (op_x),
        .op_y      (op_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
        op_valid = 1'b0; op_x = '0; op_y = '0; res_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        vectors++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready: got %b want 0", op_ready); end
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        vectors++; if (res_data !== 43'd0) begin errors++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [15:0] xs [4] = '{16'd1, 16'd3, 16'd5, 16'd7};
        logic [15:0] ys [4] = '{16'd2, 16'd4, 16'd6, 16'd8};
        cmd_valid = 1'b1; cmd_len = 11'd4;
        tick();
        cmd_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL basic_cmd_ready: got %b want 0", cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            op_valid = 1'b1; op_x = xs[i]; op_y = ys[i];
            vectors++; if (op_ready !== 1'b1) begin errors++; $display("FAIL basic_op_ready[%0d]: got %b want 1", i, op_ready); end
            tick();
        end
        op_valid = 1'b0; op_x = 16'hDEAD; op_y = 16'hBEEF;
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got %b want 0", res_valid); end
        vectors++; if (op_ready !== 1'b0) begin errors++; $display("FAIL basic_drain_op_ready: got %b want 0", op_ready); end
        tick();
        vectors++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", res_valid); end
        vectors++; if (res_data !== 43'd100) begin errors++; $display("FAIL basic_data: got %0d want 100", res_data); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL basic_idle: got valid=%b busy=%b cmd_ready=%b want 0 0 1", res_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_zero_len();
        cmd_valid = 1'b1; cmd_len = 11'd0;
        tick();
        cmd_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1) begin errors++; $display("FAIL zero_res_valid: got %b want 1", res_valid); end
        vectors++; if (res_data !== 43'd0) begin errors++; $display("FAIL zero_res_data: got %0d want 0", res_data); end
        vectors++; if (op_ready !== 1'b0) begin errors++; $display("FAIL zero_op_ready: got %b want 0", op_ready); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_idle: got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_stall_hold();
        cmd_valid = 1'b1; cmd_len = 11'd3;
        tick();
        cmd_valid = 1'b0;
        for (int p = 0; p < 3; p++) begin
            op_valid = 1'b0; op_x = 16'h1234; op_y = 16'h5678;
            tick(); tick();
            vectors++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
                errors++; $display("FAIL stall_gap[%0d]: got op_ready=%b res_valid=%b want 1 0", p, op_ready, res_valid);
            end
            op_valid = 1'b1; op_x = 16'hFFFF; op_y = 16'hFFFF;
            tick();
        end
        op_valid = 1'b0;
        tick();
        for (int w = 0; w < 5; w++) begin
            vectors++; if (res_valid !== 1'b1 || res_data !== 43'h2_FFFA_0003) begin
                errors++; $display("FAIL stall_hold[%0d]: got valid=%b data=%0h want 1 2fffa0003", w, res_valid, res_data);
            end
            tick();
        end
        // DONE with a command waiting: the command must not be taken this cycle.
        res_ready = 1'b1; cmd_valid = 1'b1; cmd_len = 11'd0;
        tick();
        res_ready = 1'b0; cmd_valid = 1'b0;
        vectors++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL stall_cmd_wait: got valid=%b busy=%b cmd_ready=%b want 0 0 1", res_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_clamp();
        int n = 0;
        cmd_valid = 1'b1; cmd_len = 11'd2000;
        tick();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_x = 16'd1; op_y = 16'd1;
        while (op_ready === 1'b1 && n < 1100) begin
            n++;
            tick();
        end
        op_valid = 1'b0;
        vectors++; if (n != 1024) begin errors++; $display("FAIL clamp_accepts: got %0d want 1024", n); end
        tick();
        vectors++; if (res_valid !== 1'b1 || res_data !== 43'd1024) begin
            errors++; $display("FAIL clamp_data: got valid=%b data=%0d want 1 1024", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        cmd_valid = 1'b1; cmd_len = 11'd5;
        tick();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_x = 16'd2; op_y = 16'd3;
        tick();
        op_x = 16'd4; op_y = 16'd5;
        tick();
        abort = 1'b1; op_x = 16'd100; op_y = 16'd100;
        #1;
        vectors++; if (op_ready !== 1'b0) begin errors++; $display("FAIL abort_op_ready: got %b want 0", op_ready); end
        tick();
        abort = 1'b0; op_valid = 1'b0;
        vectors++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy=%b cmd_ready=%b valid=%b want 0 1 0", busy, cmd_ready, res_valid);
        end
        cmd_valid = 1'b1; cmd_len = 11'd1;
        tick();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_x = 16'd9; op_y = 16'd9;
        tick();
        op_valid = 1'b0;
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_no_stale: got %b want 0", res_valid); end
        tick();
        vectors++; if (res_valid !== 1'b1 || res_data !== 43'd81) begin
            errors++; $display("FAIL abort_next_job: got valid=%b data=%0d want 1 81", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_in_done();
        cmd_valid = 1'b1; cmd_len = 11'd1;
        tick();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_x = 16'd5; op_y = 16'd5;
        tick();
        op_valid = 1'b0;
        tick();
        vectors++; if (res_valid !== 1'b1 || res_data !== 43'd25) begin
            errors++; $display("FAIL rstdone_pre: got valid=%b data=%0d want 1 25", res_valid, res_data);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        vectors++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rstdone_post: got valid=%b busy=%b cmd_ready=%b want 0 0 1", res_valid, busy, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_len = 11'd1;
        tick();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_x = 16'd2; op_y = 16'd3;
        tick();
        op_valid = 1'b0;
        tick();
        vectors++; if (res_valid !== 1'b1 || res_data !== 43'd6) begin
            errors++; $display("FAIL rstdone_job: got valid=%b data=%0d want 1 6", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  n = 0;
        bit  seen = 1'b0;
        cmd_valid = 1'b1; cmd_len = 11'd2;
        op_valid = 1'b1; op_x = 16'd3; op_y = 16'd3;
        res_ready = 1'b1;
        tick();
        do begin
            if (res_valid === 1'b1) begin
                seen = 1'b1;
                vectors++; if (res_data !== 43'd18) begin errors++; $display("FAIL b2b_data: got %0d want 18", res_data); end
            end
            tick();
            n++;
        end while (cmd_ready !== 1'b1 && n < 20);
        vectors++; if (n != 4) begin errors++; $display("FAIL b2b_occupancy: got %0d edges want 4", n); end
        vectors++; if (!seen) begin errors++; $display("FAIL b2b_result_seen: got 0 want 1"); end
        cmd_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall_hold();
        test_clamp();
        test_abort();
        test_reset_in_done();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
